// File: rtl/veririsc_pkg.sv
// Shared VeriRISC types: opcode and machine-cycle phase encodings plus ALU-class helper.
// Used by the controller, its phase sequencer and the ALU.
package veririsc_pkg;

   localparam int OPC_WIDTH   = 3;
   localparam int PHASE_WIDTH = 3;

   typedef enum logic [OPC_WIDTH-1:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_e;

   typedef enum logic [PHASE_WIDTH-1:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   // Opcodes that read a memory operand and write the accumulator.
   function automatic logic is_aluop(opcode_e op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

   function automatic phase_e next_phase(phase_e p);
      return phase_e'(p + 3'd1);
   endfunction

endpackage

// File: rtl/veririsc_ctrl_if.sv
// Controller-facing bus: opcode/zero in, control strobes and debug phase out.
// mem_ready exists only when CTRL_MEM_WAIT_EN is defined.
interface veririsc_ctrl_if;
   import veririsc_pkg::*;

   logic [OPC_WIDTH-1:0]   opcode;
   logic                   zero;
`ifdef CTRL_MEM_WAIT_EN
   logic                   mem_ready;
`endif
   logic                   sel;
   logic                   rd;
   logic                   ld_ir;
   logic                   inc_pc;
   logic                   ld_pc;
   logic                   halt;
   logic                   data_e;
   logic                   ld_ac;
   logic                   wr;
   logic [PHASE_WIDTH-1:0] phase;

   modport master (
      output opcode, zero,
`ifdef CTRL_MEM_WAIT_EN
      output mem_ready,
`endif
      input  sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
   );

   modport slave (
      input  opcode, zero,
`ifdef CTRL_MEM_WAIT_EN
      input  mem_ready,
`endif
      output sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, phase
   );

endinterface

// File: rtl/veririsc_phase_seq.sv
// Eight-phase machine-cycle counter with sticky halt; advances one phase per clk.
// With CTRL_MEM_WAIT_EN, fetch phases hold while mem_ready_i is low.
module veririsc_phase_seq
   import veririsc_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  opcode_e opcode_i,
`ifdef CTRL_MEM_WAIT_EN
   input  logic    mem_ready_i,
`endif
   output phase_e  phase_o,
   output logic    halted_o
);

   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   ready;
   logic   hold;

`ifdef CTRL_MEM_WAIT_EN
   assign ready = mem_ready_i;
`else
   assign ready = 1'b1;
`endif

   // Operand fetch only stalls when memory is actually being read.
   assign hold = !ready &&
                 ((phase_q == INST_FETCH) ||
                  ((phase_q == OP_FETCH) && is_aluop(opcode_i)));

   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (halted_q) begin
         phase_d = phase_q;
      end else if ((phase_q == OP_ADDR) && (opcode_i == HLT)) begin
         halted_d = 1'b1;
      end else if (!hold) begin
         phase_d = next_phase(phase_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   assign phase_o  = phase_q;
   assign halted_o = halted_q;

endmodule

// File: rtl/veririsc_ctrl.sv
// VeriRISC instruction-cycle controller: combinational strobe decode over the phase sequencer.
// Optional memory wait-state hold under CTRL_MEM_WAIT_EN.
module veririsc_ctrl
   import veririsc_pkg::*;
#(
   parameter int OPC_W   = 3,
   parameter int PHASE_W = 3
) (
   input  logic           clk,
   input  logic           rst,
   veririsc_ctrl_if.slave bus
);

   logic [OPC_W-1:0]   opc_raw;
   logic [PHASE_W-1:0] phase_raw;
   opcode_e            opc;
   phase_e             phase;
   logic               halted;
   logic               alu;

   logic sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;

   assign opc_raw = bus.opcode;
   assign opc     = opcode_e'(opc_raw);
   assign alu     = is_aluop(opc);

   veririsc_phase_seq u_seq (
      .clk         (clk),
      .rst         (rst),
      .opcode_i    (opc),
`ifdef CTRL_MEM_WAIT_EN
      .mem_ready_i (bus.mem_ready),
`endif
      .phase_o     (phase),
      .halted_o    (halted)
   );

   // Reset forces phase to INST_ADDR, so the reset output pattern falls out of the decode.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      halt   = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (halted) begin
         halt = 1'b1;
      end else begin
         case (phase)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               halt   = (opc == HLT);
               inc_pc = (opc != HLT);
            end
            OP_FETCH: begin
               rd = alu;
            end
            ALU_OP: begin
               rd     = alu;
               inc_pc = (opc == SKZ) && bus.zero;
               ld_pc  = (opc == JMP);
               data_e = (opc == STO);
            end
            STORE: begin
               rd     = alu;
               ld_ac  = alu;
               ld_pc  = (opc == JMP);
               wr     = (opc == STO);
               data_e = (opc == STO);
            end
            default: begin
               sel = 1'b1;
            end
         endcase
      end
   end

   assign phase_raw  = phase;
   assign bus.phase  = phase_raw;
   assign bus.sel    = sel;
   assign bus.rd     = rd;
   assign bus.ld_ir  = ld_ir;
   assign bus.inc_pc = inc_pc;
   assign bus.ld_pc  = ld_pc;
   assign bus.halt   = halt;
   assign bus.data_e = data_e;
   assign bus.ld_ac  = ld_ac;
   assign bus.wr     = wr;

endmodule

// File: tb/tb_veririsc_ctrl.sv
// Self-checking bench for veririsc_ctrl: directed opcodes, random instruction stream,
// halt, async reset; mem_ready wait states when CTRL_MEM_WAIT_EN is defined.
module tb_veririsc_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] op = 3'd2;
   logic       z = 1'b0;
   logic       mready = 1'b1;

   int vectors = 0;
   int miscompares = 0;

   int m_phase = 0;
   bit m_halted = 1'b0;

   veririsc_ctrl_if bus ();

   assign bus.opcode = op;
   assign bus.zero   = z;
`ifdef CTRL_MEM_WAIT_EN
   assign bus.mem_ready = mready;
`endif

   veririsc_ctrl #(.OPC_W(3), .PHASE_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Strobe vector order: {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}
   function automatic logic [8:0] expect_out(int ph, int o, logic zz, bit h);
      bit a, e_sel, e_rd, e_ir, e_inc, e_ldpc, e_halt, e_de, e_ac, e_wr;
      a      = (o >= 2) && (o <= 5);
      e_sel  = !h && (ph <= 3);
      e_rd   = !h && (((ph >= 1) && (ph <= 3)) || ((ph >= 5) && a));
      e_ir   = !h && ((ph == 2) || (ph == 3));
      e_inc  = !h && (((ph == 4) && (o != 0)) || ((ph == 6) && (o == 1) && (zz == 1'b1)));
      e_ldpc = !h && (ph >= 6) && (o == 7);
      e_halt = h || ((ph == 4) && (o == 0));
      e_de   = !h && (ph >= 6) && (o == 6);
      e_ac   = !h && (ph == 7) && a;
      e_wr   = !h && (ph == 7) && (o == 6);
      return {e_sel, e_rd, e_ir, e_inc, e_ldpc, e_halt, e_de, e_ac, e_wr};
   endfunction

   task automatic model_step();
      int o;
      o = int'(op);
      if (!rst) begin
         m_phase  = 0;
         m_halted = 1'b0;
      end else if (m_halted) begin
         m_phase = m_phase;
      end else if ((m_phase == 4) && (o == 0)) begin
         m_halted = 1'b1;
      end else if (!mready && ((m_phase == 1) || ((m_phase == 5) && (o >= 2) && (o <= 5)))) begin
         m_phase = m_phase;
      end else begin
         m_phase = (m_phase + 1) % 8;
      end
   endtask

   task automatic check(input string tag);
      logic [8:0] got, exp;
      logic [2:0] exp_ph;
      got    = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.halt, bus.data_e, bus.ld_ac, bus.wr};
      exp    = expect_out(m_phase, int'(op), z, m_halted);
      exp_ph = 3'(m_phase);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s strobes op=%0d phase=%0d got=%b expected=%b", tag, op, m_phase, got, exp);
      end
      vectors++;
      assert (bus.phase === exp_ph) else begin
         miscompares++;
         $error("FAIL %s phase got=%0d expected=%0d", tag, bus.phase, exp_ph);
      end
      vectors++;
      assert (((bus.ld_pc & bus.inc_pc) === 1'b0) && ((bus.wr & ~bus.data_e) === 1'b0)) else begin
         miscompares++;
         $error("FAIL %s invariant ld_pc=%b inc_pc=%b wr=%b data_e=%b expected no pc clash and wr->data_e",
                tag, bus.ld_pc, bus.inc_pc, bus.wr, bus.data_e);
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check(tag);
   endtask

   task automatic run_instr(input logic [2:0] o, input logic zz, input string tag);
      op = o;
      z  = zz;
      repeat (8) cycle(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      m_phase  = 0;
      m_halted = 1'b0;
      check(tag);
      cycle({tag, "_held"});
      rst = 1'b1;
   endtask

   initial begin
      int n;
      #3;
      check("reset");
      @(negedge clk);
      rst = 1'b1;

      run_instr(3'd2, 1'b0, "add");
      run_instr(3'd1, 1'b1, "skz_z1");
      run_instr(3'd1, 1'b0, "skz_z0");
      run_instr(3'd7, 1'b0, "jmp");
      run_instr(3'd6, 1'b1, "sto");
      run_instr(3'd5, 1'b0, "lda");

`ifdef CTRL_MEM_WAIT_EN
      op = 3'd3;
      mready = 1'b0;
      repeat (4) cycle("wait_fetch");
      mready = 1'b1;
      repeat (4) cycle("wait_go");
      mready = 1'b0;
      repeat (3) cycle("wait_opfetch");
      mready = 1'b1;
      n = 0;
      do begin cycle("wait_done"); n++; end while ((m_phase != 0) && (n < 16));
`endif

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(1, 7));
         n  = 0;
         do begin
            z = 1'($urandom);
`ifdef CTRL_MEM_WAIT_EN
            mready = ($urandom_range(0, 3) != 0);
`endif
            cycle("random");
            n++;
         end while ((m_phase != 0) && (n < 64));
      end
      mready = 1'b1;

      op = 3'd6;
      z  = 1'b0;
      n  = 0;
      while ((m_phase != 6) && (n < 16)) begin cycle("to_alu_op"); n++; end
      async_reset("midcycle_rst");

      run_instr(3'd4, 1'b1, "xor_after_rst");

      op = 3'd0;
      n  = 0;
      while (!m_halted && (n < 16)) begin cycle("to_halt"); n++; end
      repeat (20) cycle("halted");
      async_reset("halt_rst");
      run_instr(3'd2, 1'b0, "add_after_halt");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
